result_requant_collector: RTL

- Downstream stage of the weight-computation systolic chain.
- Consumes the result bus leaving the last compute cell. That bus is {valid, signed accumulator}: the MSB flags a valid result, and results may arrive back-to-back.
- Requantises each signed accumulator to an unsigned 8-bit activation (round, shift, offset, clamp) and tags the last neuron of each input vector.
- Buffers results in a small FIFO and presents them on a valid/ready stream to the next layer's input feeder. The chain cannot be stalled, so a full FIFO drops results and raises a sticky flag.

---
 rtl/layer_pkg.sv | 19 +
 rtl/result_requant_collector_if.sv | 14 +
 rtl/sync_fifo.sv | 51 +++++
 rtl/result_requant_collector.sv | 78 +++++++
 4 files changed

// File: rtl/layer_pkg.sv
// layer_pkg: activation width, result-bus layout and clamp bounds shared by the
// layer's feeder and collector stages.
package layer_pkg;

    localparam int ACT_WIDTH = 8;
    localparam int ACT_MIN   = 0;
    localparam int ACT_MAX   = 255;

    typedef struct packed {
        logic                 last;
        logic [ACT_WIDTH-1:0] data;
    } act_entry_t;

    // The valid flag sits directly above the accumulator on every result bus.
    function automatic int valid_bit(input int result_width);
        return result_width;
    endfunction

endpackage

// File: rtl/result_requant_collector_if.sv
// result_requant_collector_if: activation stream from the collector to the next
// layer's input feeder.
interface result_requant_collector_if;
    import layer_pkg::*;

    logic [ACT_WIDTH-1:0] out_data;
    logic                 out_last;
    logic                 out_valid;
    logic                 out_ready;

    modport master (output out_data, output out_last, output out_valid, input out_ready);
    modport slave  (input out_data, input out_last, input out_valid, output out_ready);

endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead single-clock FIFO with exact occupancy count; when empty
// the read port keeps showing the last entry read.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] hold;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             push, pop;

    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign pop   = rd_en && !empty;
    // A full FIFO still takes a write when a read frees a slot on the same edge.
    assign push  = wr_en && (!full || pop);
    assign rd_data = empty ? hold : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            hold   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                hold   <= mem[rd_ptr];
            end
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/result_requant_collector.sv
// result_requant_collector: requantises systolic-chain accumulators to unsigned
// activations, tags each vector's last neuron and buffers them on a stream.
module result_requant_collector
    import layer_pkg::*;
#(
    parameter int RESULT_WIDTH  = 16,
    parameter int SHIFT         = 4,
    parameter int OUTPUT_OFFSET = 0,
    parameter int FIFO_DEPTH    = 8,
    parameter int NEURON_COUNT  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [RESULT_WIDTH:0]         input_result,
    result_requant_collector_if.master    stream,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level
);
    localparam int SW = RESULT_WIDTH + 2;
    localparam int CW = NEURON_COUNT > 1 ? $clog2(NEURON_COUNT) : 1;
    localparam int VB = valid_bit(RESULT_WIDTH);
    localparam logic signed [SW-1:0] RND = SW'((2 ** SHIFT) / 2);

    logic                 in_valid, s1_valid, s1_last, fifo_full, fifo_empty, pop;
    logic signed [SW-1:0] acc_ext, sum_d, s1_sum;
    logic [CW-1:0]        neuron_cnt;
    act_entry_t           push_entry, head;

    assign in_valid = input_result[VB];
    assign acc_ext  = SW'($signed(input_result[RESULT_WIDTH-1:0]));
    // Two guard bits keep round + offset from wrapping before the clamp.
    assign sum_d    = ((acc_ext + RND) >>> SHIFT) + SW'(OUTPUT_OFFSET);

    assign push_entry.last = s1_last;
    assign push_entry.data = s1_sum[SW-1] ? ACT_WIDTH'(ACT_MIN) :
                             |s1_sum[SW-2:ACT_WIDTH] ? ACT_WIDTH'(ACT_MAX) :
                             s1_sum[ACT_WIDTH-1:0];

    assign pop = stream.out_valid && stream.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_last    <= 1'b0;
            s1_sum     <= '0;
            neuron_cnt <= '0;
            overflow   <= 1'b0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sum     <= sum_d;
                s1_last    <= neuron_cnt == CW'(NEURON_COUNT - 1);
                neuron_cnt <= neuron_cnt == CW'(NEURON_COUNT - 1) ? '0 : neuron_cnt + 1'b1;
            end
            if (s1_valid && fifo_full && !pop) overflow <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(act_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (s1_valid),
        .wr_data (push_entry),
        .rd_en   (stream.out_ready),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fill_level)
    );

    assign stream.out_data  = head.data;
    assign stream.out_last  = head.last;
    assign stream.out_valid = !fifo_empty;

endmodule
